// File: rtl/ptmch_pkg.sv
// Shared definitions for the SPI command match/trigger subsystem:
// register offsets, CTRL field positions, receiver states and channel config.
package ptmch_pkg;

  localparam logic [3:0]  OFF_CTRL  = 4'h0;
  localparam logic [3:0]  OFF_LOW   = 4'h4;
  localparam logic [3:0]  OFF_HIGH  = 4'h8;
  localparam logic [3:0]  OFF_COUNT = 4'hC;
  localparam logic [15:0] ADDR_INFO = 16'h0100;

  localparam int unsigned CTRL_EN_BIT   = 0;
  localparam int unsigned CTRL_ACHK_BIT = 1;
  localparam int unsigned CTRL_OPC_LSB  = 8;

  typedef enum logic [1:0] {
    IDLE,
    OPC,
    ADDR,
    DONE
  } rx_state_t;

  typedef struct packed {
    logic        en;
    logic        addr_chk;
    logic [7:0]  opcode;
    logic [31:0] low;
    logic [31:0] high;
  } ch_cfg_t;

endpackage

// File: rtl/ptmch_spi_rx.sv
// Passive SPI mode-0 frame decoder: synchronises the bus, then strobes the
// opcode after 8 bits and the address after 8*ADDR_BYTES further bits.
module ptmch_spi_rx
  import ptmch_pkg::*;
#(
  parameter int unsigned ADDR_BYTES  = 3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    spi_cs,
  input  logic                    spi_clk,
  input  logic                    spi_mosi,
  output logic                    opc_valid,
  output logic [7:0]              opc,
  output logic                    addr_valid,
  output logic [8*ADDR_BYTES-1:0] addr
);

  localparam int unsigned AW = 8 * ADDR_BYTES;

  logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, mosi_sync;
  logic cs_s, sclk_s, mosi_s, cs_d, sclk_d;
  logic cs_fall, cs_rise, sclk_rise, bit_in;

  rx_state_t state, state_nxt;
  logic [5:0]    bit_cnt, cnt_nxt;
  logic [AW-1:0] sh, sh_nxt;
  logic          opc_done, addr_done;

  // CS synchroniser resets high so leaving reset never looks like a frame start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync   <= '1;
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_d      <= 1'b1;
      sclk_d    <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      cs_d      <= cs_s;
      sclk_d    <= sclk_s;
    end
  end

  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign cs_fall   = cs_d & ~cs_s;
  assign cs_rise   = ~cs_d & cs_s;
  assign sclk_rise = sclk_s & ~sclk_d;
  assign bit_in    = sclk_rise & ~cs_s;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = bit_cnt;
    sh_nxt    = sh;
    opc_done  = 1'b0;
    addr_done = 1'b0;
    if (cs_rise) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state_nxt = OPC;
            cnt_nxt   = '0;
          end
        end
        OPC: begin
          if (bit_in) begin
            sh_nxt = {sh[AW-2:0], mosi_s};
            if (bit_cnt == 6'd7) begin
              opc_done  = 1'b1;
              state_nxt = ADDR;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = bit_cnt + 6'd1;
            end
          end
        end
        ADDR: begin
          if (bit_in) begin
            sh_nxt = {sh[AW-2:0], mosi_s};
            if (bit_cnt == 6'(AW - 1)) begin
              addr_done = 1'b1;
              state_nxt = DONE;
            end else begin
              cnt_nxt = bit_cnt + 6'd1;
            end
          end
        end
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      sh         <= '0;
      opc_valid  <= 1'b0;
      opc        <= '0;
      addr_valid <= 1'b0;
      addr       <= '0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= cnt_nxt;
      sh         <= sh_nxt;
      opc_valid  <= opc_done;
      addr_valid <= addr_done;
      if (opc_done)  opc  <= sh_nxt[7:0];
      if (addr_done) addr <= sh_nxt;
    end
  end

endmodule

// File: rtl/ptmch_mch.sv
// SPI command match channels with trigger pulses, hit counters and an
// Avalon-MM register file. Define PTMCH_TIMESTAMP_EN for per-channel hit timestamps.
module ptmch_mch
  import ptmch_pkg::*;
#(
  parameter int unsigned NUM_CH      = 5,
  parameter int unsigned ADDR_BYTES  = 3,
  parameter int unsigned PULSE_LEN   = 4,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              CLK160M,
  input  logic              RESET_N,
  input  logic              SPI_CS,
  input  logic              SPI_CLK,
  input  logic              SPI_MOSI,
  output logic [NUM_CH-1:0] TRG_PLS,
  input  logic              REG_BEGINTRANSFER,
  input  logic [15:0]       REG_ADDRESS,
  input  logic              REG_CS,
  input  logic              REG_READ,
  input  logic              REG_WRITE,
  input  logic [31:0]       REG_WRITEDATA,
  output logic [31:0]       REG_READDATA,
  output logic              REG_WAITREQUEST
);

  localparam int unsigned AW = 8 * ADDR_BYTES;
  localparam int unsigned PW = $clog2(PULSE_LEN + 1);
`ifdef PTMCH_TIMESTAMP_EN
  localparam logic TS_FLAG = 1'b1;
`else
  localparam logic TS_FLAG = 1'b0;
`endif
  localparam logic [31:0] INFO_WORD = {8'(NUM_CH), 4'(ADDR_BYTES), 18'h0, 1'b1, TS_FLAG};

  logic          opc_valid, addr_valid;
  logic [7:0]    opc;
  logic [AW-1:0] addr;

  ptmch_spi_rx #(
    .ADDR_BYTES (ADDR_BYTES),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rx (
    .clk       (CLK160M),
    .rst_n     (RESET_N),
    .spi_cs    (SPI_CS),
    .spi_clk   (SPI_CLK),
    .spi_mosi  (SPI_MOSI),
    .opc_valid (opc_valid),
    .opc       (opc),
    .addr_valid(addr_valid),
    .addr      (addr)
  );

  logic       wr_en, page0, rd_req, rd_ack;
  logic [3:0] chi;
  logic [1:0] woff;
  logic [31:0] rd_mux;
  logic [31:0] ch_rdata [NUM_CH];
  logic unused_bits;

  assign wr_en = REG_CS & REG_WRITE;
  assign page0 = (REG_ADDRESS[15:8] == 8'h00);
  assign chi   = REG_ADDRESS[7:4];
  assign woff  = REG_ADDRESS[3:2];
  assign unused_bits = ^{REG_BEGINTRANSFER, REG_ADDRESS[1:0], REG_WRITEDATA};

`ifdef PTMCH_TIMESTAMP_EN
  logic [31:0] ts_cnt;
  logic [31:0] ch_ts [NUM_CH];

  always_ff @(posedge CLK160M or negedge RESET_N) begin
    if (!RESET_N) ts_cnt <= '0;
    else          ts_cnt <= ts_cnt + 32'd1;
  end
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ch_cfg_t        cfg;
    logic [CNT_W-1:0] cnt;
    logic [PW-1:0]  pcnt;
    logic           fired, sel, clr, opc_eq, in_win, hit_opc, hit_addr, hit;
    logic [31:0]    rd;

    assign sel      = wr_en & page0 & (chi == 4'(g));
    assign clr      = sel & (woff == OFF_COUNT[3:2]);
    assign opc_eq   = cfg.en & (cfg.opcode == opc);
    assign in_win   = (cfg.low <= 32'(addr)) && (32'(addr) <= cfg.high);
    assign hit_opc  = opc_valid & opc_eq & ~cfg.addr_chk;
    assign hit_addr = addr_valid & opc_eq & cfg.addr_chk & in_win & ~fired;
    assign hit      = hit_opc | hit_addr;
    assign TRG_PLS[g] = (pcnt != '0);

    always_ff @(posedge CLK160M or negedge RESET_N) begin
      if (!RESET_N) begin
        cfg <= '0;
      end else if (sel) begin
        case (woff)
          OFF_CTRL[3:2]: begin
            cfg.en       <= REG_WRITEDATA[CTRL_EN_BIT];
            cfg.addr_chk <= REG_WRITEDATA[CTRL_ACHK_BIT];
            cfg.opcode   <= REG_WRITEDATA[CTRL_OPC_LSB +: 8];
          end
          OFF_LOW[3:2]:  cfg.low  <= 32'(REG_WRITEDATA[AW-1:0]);
          OFF_HIGH[3:2]: cfg.high <= 32'(REG_WRITEDATA[AW-1:0]);
          default: ;
        endcase
      end
    end

    // opc_valid opens every frame's evaluation, so it also rearms the once-per-frame guard
    always_ff @(posedge CLK160M or negedge RESET_N) begin
      if (!RESET_N) begin
        fired <= 1'b0;
        pcnt  <= '0;
        cnt   <= '0;
      end else begin
        if (opc_valid)     fired <= hit_opc;
        else if (hit_addr) fired <= 1'b1;

        if (hit)               pcnt <= PW'(PULSE_LEN);
        else if (pcnt != '0)   pcnt <= pcnt - 1'b1;

        if (clr)                     cnt <= hit ? CNT_W'(1) : '0;
        else if (hit && cnt != '1)   cnt <= cnt + 1'b1;
      end
    end

`ifdef PTMCH_TIMESTAMP_EN
    logic [31:0] ts_hit;
    always_ff @(posedge CLK160M or negedge RESET_N) begin
      if (!RESET_N)  ts_hit <= '0;
      else if (hit)  ts_hit <= ts_cnt;
    end
    assign ch_ts[g] = ts_hit;
`endif

    always_comb begin
      rd = '0;
      case (woff)
        OFF_CTRL[3:2]: begin
          rd[CTRL_EN_BIT]         = cfg.en;
          rd[CTRL_ACHK_BIT]       = cfg.addr_chk;
          rd[CTRL_OPC_LSB +: 8]   = cfg.opcode;
        end
        OFF_LOW[3:2]:   rd = cfg.low;
        OFF_HIGH[3:2]:  rd = cfg.high;
        OFF_COUNT[3:2]: rd = 32'(cnt);
        default:        rd = '0;
      endcase
    end
    assign ch_rdata[g] = rd;
  end

  always_comb begin
    rd_mux = '0;
    if (REG_ADDRESS[15:2] == ADDR_INFO[15:2]) begin
      rd_mux = INFO_WORD;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (page0 && chi == 4'(i)) rd_mux = ch_rdata[i];
`ifdef PTMCH_TIMESTAMP_EN
        if (REG_ADDRESS[15:2] == 14'((16 * NUM_CH + 4 * i) >> 2)) rd_mux = ch_ts[i];
`endif
      end
    end
  end

  // One wait cycle per read: rd_ack marks the data cycle and drops again after it
  assign rd_req          = REG_CS & REG_READ;
  assign REG_WAITREQUEST = rd_req & ~rd_ack;

  always_ff @(posedge CLK160M or negedge RESET_N) begin
    if (!RESET_N) begin
      rd_ack       <= 1'b0;
      REG_READDATA <= '0;
    end else begin
      rd_ack <= REG_WAITREQUEST;
      if (REG_WAITREQUEST) REG_READDATA <= rd_mux;
    end
  end

endmodule

// File: tb/tb_ptmch_mch.sv
// Directed bench for ptmch_mch: trigger masks and register reads are queued as
// expectations and checked by an independent monitor on the falling clock edge.
module tb_ptmch_mch;

  localparam int unsigned NCH  = 5;
  localparam int unsigned PLEN = 4;
  localparam int unsigned SYNC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spi_cs = 1'b1, spi_clk = 1'b0, spi_mosi = 1'b0;
  logic [NCH-1:0] trg;
  logic        reg_bt = 1'b0;
  logic [15:0] reg_addr = '0;
  logic        reg_cs = 1'b0, reg_rd = 1'b0, reg_wr = 1'b0;
  logic [31:0] reg_wd = '0;
  logic [31:0] reg_rdata;
  logic        reg_wait;

  int compares = 0;
  int errors   = 0;

  logic [NCH-1:0] trig_q [$];
  logic [31:0]    rd_exp_q [$];
  logic [15:0]    rd_addr_q [$];
  event           bit8_ev;

  ptmch_mch #(
    .NUM_CH     (NCH),
    .ADDR_BYTES (3),
    .PULSE_LEN  (PLEN),
    .CNT_W      (4),
    .SYNC_STAGES(SYNC)
  ) dut (
    .CLK160M          (clk),
    .RESET_N          (rst_n),
    .SPI_CS           (spi_cs),
    .SPI_CLK          (spi_clk),
    .SPI_MOSI         (spi_mosi),
    .TRG_PLS          (trg),
    .REG_BEGINTRANSFER(reg_bt),
    .REG_ADDRESS      (reg_addr),
    .REG_CS           (reg_cs),
    .REG_READ         (reg_rd),
    .REG_WRITE        (reg_wr),
    .REG_WRITEDATA    (reg_wd),
    .REG_READDATA     (reg_rdata),
    .REG_WAITREQUEST  (reg_wait)
  );

  always #3 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Monitor: trigger rise masks, pulse lengths, completed reads
  initial begin
    logic [NCH-1:0] prev, rise, e;
    int hi_len [NCH];
    logic [31:0] ev;
    logic [15:0] ea;
    prev = '0;
    for (int i = 0; i < NCH; i++) hi_len[i] = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = '0;
        for (int i = 0; i < NCH; i++) hi_len[i] = 0;
      end else begin
        rise = trg & ~prev;
        if (rise != '0) begin
          compares++;
          if (trig_q.size() == 0) begin
            errors++;
            $display("FAIL trig_unexpected: got=%b required=none", rise);
          end else begin
            e = trig_q.pop_front();
            if (rise !== e) begin
              errors++;
              $display("FAIL trig_mask: got=%b required=%b", rise, e);
            end
          end
        end
        for (int i = 0; i < NCH; i++) begin
          if (trg[i]) hi_len[i]++;
          else if (hi_len[i] != 0) begin
            compares++;
            if (hi_len[i] != PLEN) begin
              errors++;
              $display("FAIL pulse_len ch%0d: got=%0d required=%0d", i, hi_len[i], PLEN);
            end
            hi_len[i] = 0;
          end
        end
        prev = trg;
      end
      if (reg_cs && reg_rd && !reg_wait) begin
        compares++;
        if (rd_exp_q.size() == 0) begin
          errors++;
          $display("FAIL rd_unexpected addr=%h: got=%h required=none", reg_addr, reg_rdata);
        end else begin
          ev = rd_exp_q.pop_front();
          ea = rd_addr_q.pop_front();
          if (reg_rdata !== ev) begin
            errors++;
            $display("FAIL rd addr=%h: got=%h required=%h", ea, reg_rdata, ev);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    reg_addr = a; reg_wd = d; reg_cs = 1'b1; reg_wr = 1'b1;
    @(posedge clk); #1;
    reg_cs = 1'b0; reg_wr = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [31:0] exp);
    int n;
    bit done;
    n = 0; done = 1'b0;
    rd_addr_q.push_back(a);
    rd_exp_q.push_back(exp);
    @(posedge clk); #1;
    reg_addr = a; reg_cs = 1'b1; reg_rd = 1'b1;
    while (!done && n < 16) begin
      @(negedge clk);
      if (!reg_wait) done = 1'b1;
      n++;
    end
    if (!done) begin
      compares++; errors++;
      $display("FAIL rd_timeout addr=%h: got=waitrequest required=data", a);
      void'(rd_exp_q.pop_back());
      void'(rd_addr_q.pop_back());
    end
    @(posedge clk); #1;
    reg_cs = 1'b0; reg_rd = 1'b0;
  endtask

  task automatic rd_b2b(input logic [15:0] a0, input logic [31:0] e0,
                        input logic [15:0] a1, input logic [31:0] e1);
    logic [3:0] w;
    rd_addr_q.push_back(a0); rd_exp_q.push_back(e0);
    rd_addr_q.push_back(a1); rd_exp_q.push_back(e1);
    @(posedge clk); #1;
    reg_addr = a0; reg_cs = 1'b1; reg_rd = 1'b1;
    @(negedge clk); w[3] = reg_wait;
    @(negedge clk); w[2] = reg_wait;
    @(posedge clk); #1; reg_addr = a1;
    @(negedge clk); w[1] = reg_wait;
    @(negedge clk); w[0] = reg_wait;
    @(posedge clk); #1;
    reg_cs = 1'b0; reg_rd = 1'b0;
    compares++;
    if (w !== 4'b1010) begin
      errors++;
      $display("FAIL waitreq_pattern: got=%b required=1010", w);
    end
  endtask

  task automatic spi_frame(input logic [31:0] data, input int unsigned nbits);
    spi_cs = 1'b0;
    tick(4);
    for (int unsigned i = 0; i < nbits; i++) begin
      spi_mosi = data[31-i];
      tick(4);
      spi_clk = 1'b1;
      if (i == 7) -> bit8_ev;
      tick(4);
      spi_clk = 1'b0;
    end
    tick(4);
    spi_cs = 1'b1;
    tick(12);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (trig_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    compares++;
    if (trig_q.size() != 0) begin
      errors++;
      $display("FAIL trig_missing: got=%0d pending required=0", trig_q.size());
      trig_q.delete();
    end
    tick(PLEN + 4);
  endtask

  initial begin
    tick(5);
    rst_n = 1'b1;
    tick(3);

    // Reset state
    compares++;
    if (trg !== '0 || reg_wait !== 1'b0 || reg_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: got=%b/%b/%h required=0/0/0", trg, reg_wait, reg_rdata);
    end
    rd(16'h0000, 32'h0);
    rd(16'h000C, 32'h0);

    // 1: ch0 opcode-only match
    wr(16'h0000, 32'h0000_1001);
    rd(16'h0000, 32'h0000_1001);
    trig_q.push_back(5'b00001);
    spi_frame(32'h1000_1234, 32);
    drain();
    rd(16'h000C, 32'h1);
    rd(16'h001C, 32'h0);
    rd(16'h002C, 32'h0);

    // 2: ch2 address window, inclusive upper bound and inverted window
    wr(16'h0020, 32'h0000_D803);
    wr(16'h0024, 32'h0000_0100);
    wr(16'h0028, 32'h0000_01FF);
    rd(16'h0028, 32'h0000_01FF);
    trig_q.push_back(5'b00100);
    spi_frame(32'hD800_01FF, 32);
    drain();
    spi_frame(32'hD800_0200, 32);
    drain();
    rd(16'h002C, 32'h1);
    wr(16'h0024, 32'h0000_0200);
    wr(16'h0028, 32'h0000_0100);
    spi_frame(32'hD800_0180, 32);
    drain();
    rd(16'h002C, 32'h1);
    wr(16'h0024, 32'h0000_0100);
    wr(16'h0028, 32'h0000_01FF);

    // 3: two channels on the same opcode fire together
    wr(16'h0010, 32'h0000_1301);
    wr(16'h0030, 32'h0000_1301);
    trig_q.push_back(5'b01010);
    spi_frame(32'h1300_0000, 8);
    drain();
    rd(16'h001C, 32'h1);
    rd(16'h003C, 32'h1);

    // 4: aborted frame, then reset during an active pulse
    spi_frame(32'hD800_0150, 24);
    drain();
    rd(16'h002C, 32'h1);
    trig_q.push_back(5'b00001);
    fork
      spi_frame(32'h1000_0150, 32);
      begin
        int n;
        n = 0;
        while (!trg[0] && n < 400) begin
          @(negedge clk);
          n++;
        end
        compares++;
        if (!trg[0]) begin
          errors++;
          $display("FAIL reset_pulse_seen: got=0 required=1");
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        tick(2);
        compares++;
        if (trg !== '0) begin
          errors++;
          $display("FAIL reset_trg: got=%b required=00000", trg);
        end
        rst_n = 1'b1;
      end
    join
    drain();
    for (int i = 0; i < NCH; i++) rd(16'(i * 16), 32'h0);
    rd(16'h002C, 32'h0);

    // 5: saturation at 0xF, then clear coincident with a hit
    wr(16'h0040, 32'h0000_5501);
    for (int i = 0; i < 16; i++) begin
      trig_q.push_back(5'b10000);
      spi_frame(32'h5500_0000, 8);
    end
    drain();
    rd(16'h004C, 32'hF);
    trig_q.push_back(5'b10000);
    fork
      spi_frame(32'h5500_0000, 8);
      begin
        @(bit8_ev);
        repeat (SYNC + 1) @(posedge clk);
        #1;
        reg_addr = 16'h004C; reg_wd = 32'h0; reg_cs = 1'b1; reg_wr = 1'b1;
        @(posedge clk); #1;
        reg_cs = 1'b0; reg_wr = 1'b0;
      end
    join
    drain();
    rd(16'h004C, 32'h1);
    wr(16'h004C, 32'h0);
    rd(16'h004C, 32'h0);

    // 6: back-to-back reads, INFO, timestamp slots, unmapped space
    rd_b2b(16'h0100, 32'h0530_0002, 16'h000C, 32'h0);
    rd(16'h0050, 32'h0);
    rd(16'h0060, 32'h0);
    wr(16'h0200, 32'hDEAD_BEEF);
    rd(16'h0200, 32'h0);
    rd(16'h0103, 32'h0530_0002);

    tick(4);
    compares++;
    if (rd_exp_q.size() != 0 || trig_q.size() != 0) begin
      errors++;
      $display("FAIL queues_empty: got=%0d/%0d required=0/0", rd_exp_q.size(), trig_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
    $finish;
  end

endmodule

// File: doc/ptmch_mch.md
Name: ptmch_mch

Overview:
- Parametrised, single-clock successor of the SPI command trigger/counter subsystem.
- Passively sniffs an SPI flash bus and decodes opcode plus address per frame.
- Compares each frame against NUM_CH independently programmable channels (opcode, address window, mode).
- Per matching channel: emits a fixed-length trigger pulse and increments a hit counter. All configuration and counters sit behind an Avalon-MM slave in the same clock domain.

Parameters:
- NUM_CH, 5: number of match channels (1..16).
- ADDR_BYTES, 3: address bytes following the opcode (1..4).
- PULSE_LEN, 4: TRG_PLS high time in CLK160M cycles (>=1).
- CNT_W, 32: hit counter width (<=32).
- SYNC_STAGES, 2: synchroniser depth on the SPI inputs (>=2).

Ports:
- CLK160M  in  1  sole clock.
- RESET_N  in  1  reset, asynchronous, active-low.
- SPI_CS  in  1  SPI chip select, active-low, asynchronous.
- SPI_CLK  in  1  SPI clock, mode 0, asynchronous, <= CLK160M/4.
- SPI_MOSI  in  1  SPI data, MSB first, asynchronous.
- TRG_PLS  out  NUM_CH  per-channel trigger pulse.
- REG_BEGINTRANSFER  in  1  Avalon begin transfer (unused internally, kept for bus compatibility).
- REG_ADDRESS  in  16  byte address; bits[1:0] ignored.
- REG_CS  in  1  slave select.
- REG_READ  in  1  read strobe.
- REG_WRITE  in  1  write strobe.
- REG_WRITEDATA  in  32  write data.
- REG_READDATA  out  32  read data.
- REG_WAITREQUEST  out  1  wait request.

Behaviour:

Reset
- All outputs reset to 0.
- All channel registers reset to 0, so every channel is disabled.
- Receiver state resets to IDLE.

Receiver
- SPI inputs pass through SYNC_STAGES flip-flops.
- A bit is sampled on a synced SPI_CLK rising edge while synced CS is low.
- FSM states and transitions:
  - IDLE -> OPC on CS falling.
  - OPC -> ADDR after 8 bits; the opcode is latched.
  - ADDR -> DONE after 8*ADDR_BYTES bits.
  - DONE: further bits are ignored.
  - Any state -> IDLE on CS rising.
- CS rising before a required byte completes aborts the frame; no trigger fires.

Match rules
- Channel ch is a hit when all of the following hold:
  - EN=1 and OPCODE equals the latched opcode.
  - If ADDR_CHK=0: the hit is evaluated in the cycle the opcode byte completes.
  - If ADDR_CHK=1: the hit is evaluated when the address completes, and requires LOW <= addr <= HIGH, unsigned and inclusive. LOW > HIGH never matches.
- A channel hits at most once per frame.
- Several channels may hit in the same frame; all of them fire in the same cycle.

Trigger and counters
- TRG_PLS[ch] rises 1 cycle after the hit cycle and stays high for PULSE_LEN cycles.
- A new hit while the pulse is active restarts the length count.
- COUNT[ch] increments in the cycle after the hit and saturates at all-ones.
- A write-clear in the same cycle as an increment gives COUNT=1.

Register map (per channel, base = ch*0x10)
- +0x0 CTRL: bit0 EN, bit1 ADDR_CHK, bits15:8 OPCODE. Read/write.
- +0x4 LOW: low address bound, lower 8*ADDR_BYTES bits. Read/write.
- +0x8 HIGH: high address bound, same width. Read/write.
- +0xC COUNT: read returns the count zero-extended; any write clears it.
- 0x100 INFO: read-only, {NUM_CH[7:0], ADDR_BYTES[3:0], 20'h0_0002}.
- Unmapped addresses read 0; writes to them are ignored.

Avalon handshake
- Writes complete with zero wait; WAITREQUEST stays 0.
- Reads: WAITREQUEST=1 in the first cycle of REG_CS&REG_READ, 0 in the next cycle. REG_READDATA is valid in that next cycle and held until the next read.
- Configuration written mid-frame takes effect at the next evaluation point.

Optional Feature:
- Macro: PTMCH_TIMESTAMP_EN.
- When defined:
  - A free-running 32-bit cycle counter runs from reset.
  - Each channel gains a read-only register at +0x10*NUM_CH + 4*ch holding the timestamp of its last hit (captured in the hit cycle).
  - INFO bit0 reads 1.
- When undefined: no timestamp logic, those addresses read 0, INFO bit0 reads 0.

Decomposition:
- Package ptmch_pkg holds:
  - register offset localparams (CTRL/LOW/HIGH/COUNT/INFO);
  - CTRL field positions;
  - the receiver state enum typedef (IDLE, OPC, ADDR, DONE);
  - the channel config struct typedef {en, addr_chk, opcode, low, high}.
- One sub-module, ptmch_spi_rx, contains the synchroniser, edge detect, FSM and shifter. Its outputs are opc_valid/opc and addr_valid/addr strobes.
- Match logic, pulse generation, counters and the register file stay in the top module via a generate loop over NUM_CH.

Test Plan:
1. Ch0 CTRL=0x1001 (opcode 0x10, EN=1, ADDR_CHK=0); frame 0x10,0x00,0x12,0x34 -> TRG_PLS[0] high 4 cycles; COUNT0 reads 1; other channels stay 0.
2. Ch2: opcode 0xD8, ADDR_CHK=1, LOW=0x000100, HIGH=0x0001FF. Address 0x0001FF -> pulse. Address 0x000200 -> no pulse; COUNT2=1. With LOW=0x200, HIGH=0x100, address 0x000180 -> no pulse.
3. Ch1 and ch3 both opcode 0x13, ADDR_CHK=0; frame 0x13 -> TRG_PLS[1] and TRG_PLS[3] rise in the same cycle; both counts are 1.
4. Ch2 from scenario 2, address 0x000150: CS raised after 2 address bytes -> no pulse, count unchanged. Then RESET_N pulsed low mid-frame -> TRG_PLS=0, all CTRL read 0.
5. Preload COUNT near saturation by forcing CNT_W=4 and driving 16 hits -> count reads 0xF. Write COUNT coincident with a hit -> reads 1.
6. Back-to-back reads of 0x100 and 0x00C -> WAITREQUEST pattern 1,0,1,0. INFO reads 0x0530_0002 with PTMCH_TIMESTAMP_EN undefined; its timestamp addresses read 0.
